fetch_luma_load_ctrl: RTL and testbench
=======================================

FETCH_LUMA_LOAD_CTRL -- requirements
Module: fetch_luma_load_ctrl

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default `PIXEL_WIDTH (8), bits per luma sample.
REQ-002 SHALL have parameter LOAD_ROWS, default 80, reference-window rows per LCU.
REQ-003 SHALL have parameter BEATS_PER_ROW, default 3, 32-pixel beats per 96-pixel row.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sysif_start_i  input  1  LCU-start pulse; the same pulse that rotates the luma buffers.
REQ-007 SHALL have port sysif_total_x_i  input  `PIC_X_WIDTH  last LCU column index.
REQ-008 SHALL have port sysif_total_y_i  input  `PIC_Y_WIDTH  last LCU row index.
REQ-009 SHALL have port ext_req_o  output  1  window fetch request, held until acknowledged.
REQ-010 SHALL have port ext_req_x_o  output  `PIC_X_WIDTH  requested LCU column.
REQ-011 SHALL have port ext_req_y_o  output  `PIC_Y_WIDTH  requested LCU row.
REQ-012 SHALL have port ext_ack_i  input  1  request accepted.
REQ-013 SHALL have port ext_rdata_valid_i  input  1  beat valid.
REQ-014 SHALL have port ext_rdata_i  input  32*PIXEL_WIDTH  beat data, leftmost pixel in MSBs.
REQ-015 SHALL have port ext_load_valid_o  output  1  row write strobe to the luma buffer.
REQ-016 SHALL have port ext_load_addr_o  output  7  row address 0..LOAD_ROWS-1.
REQ-017 SHALL have port ext_load_data_o  output  96*PIXEL_WIDTH  assembled row, beat 0 in MSBs.
REQ-018 SHALL have port ext_load_done_o  output  1  one-cycle window-complete pulse.
REQ-019 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, LOAD, DONE.
REQ-021 IDLE -> REQ on sysif_start_i; ext_req_x_o and ext_req_y_o SHALL be driven from the current LCU position register.
REQ-022 REQ: ext_req_o=1, with x and y stable, until the cycle ext_ack_i=1; that cycle SHALL move the FSM to LOAD.
REQ-023 In LOAD, the beat counter 0..BEATS_PER_ROW-1 SHALL advance only on ext_rdata_valid_i; beat k lands at bits [(96-32k)*PIXEL_WIDTH-1 -: 32*PIXEL_WIDTH].
REQ-024 On the last beat of a row, the module SHALL assert ext_load_valid_o for exactly one cycle, in the next cycle, with the registered row and the current row counter as ext_load_addr_o; the row counter SHALL then increment.
REQ-025 After row LOAD_ROWS-1 is written, the FSM SHALL go to DONE, and ext_load_done_o SHALL pulse for one cycle, the cycle after that row's ext_load_valid_o.
REQ-026 DONE -> IDLE unconditionally after one cycle; the row and beat counters SHALL clear.
REQ-027 The LCU position SHALL advance on each accepted start: x+1; at x==sysif_total_x_i, x=0 and y+1; at (total_x,total_y), wrap to (0,0).
REQ-028 sysif_start_i while busy_o=1 SHALL be ignored: no position change and no effect on the load in progress.
REQ-029 ext_rdata_valid_i outside LOAD SHALL be discarded with no output activity.
REQ-030 Gaps between beats SHALL be tolerated; partial row data SHALL be held indefinitely.
REQ-031 sysif_start_i in the same cycle as the DONE->IDLE transition SHALL be ignored; it is accepted only in IDLE.

Reset
REQ-032 Asynchronous assertion of rstn SHALL force: FSM=IDLE; position=(0,0); counters=0; ext_req_o, ext_load_valid_o, ext_load_done_o, busy_o=0; ext_load_addr_o=0; ext_load_data_o=0.
REQ-033 Reset mid-load SHALL abandon the window with no done pulse.

Structure
REQ-034 LOAD_ROWS, BEATS_PER_ROW and the FSM state encodings SHALL live in the shared enc_defines include.
REQ-035 A sub-module fetch_luma_row_pack SHALL hold the beat counter and row register and emit the row strobe; the top level SHALL hold the FSM, the row counter and the position.

Verification
REQ-036 Reset, then start, ack after 2 cycles, 240 back-to-back beats -> req x=0,y=0; 80 strobes with addr 0..79; done 1 cycle after addr 79.
REQ-037 Beat values 0x01.., 0x02.., 0x03.. -> row MSB slice = beat0, LSB slice = beat2.
REQ-038 total_x=2, total_y=1, six full loads -> request positions (0,0),(1,0),(2,0),(0,1),(1,1),(2,1), then (0,0) on the seventh.
REQ-039 Start pulsed at row 40 of a load -> ignored; the next request still uses the next position; 80 rows total.
REQ-040 Random 0-5 cycle valid gaps -> identical rows and addresses as the back-to-back case.
REQ-041 rstn low at row 50 -> all outputs 0, no done; the next start requests (0,0).

Source files
------------

// File: rtl/fetch_luma_load_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the luma reference-window loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_luma_load_ctrl_pkg;

    localparam int PIXEL_WIDTH_DEF   = 8;   // bits per luma sample
    localparam int PIC_X_WIDTH       = 8;   // LCU column index width
    localparam int PIC_Y_WIDTH       = 8;   // LCU row index width
    localparam int LOAD_ROWS_DEF     = 80;  // reference-window rows per LCU
    localparam int BEATS_PER_ROW_DEF = 3;   // 32-pixel beats per 96-pixel row
    localparam int BEAT_PIXELS       = 32;  // pixels carried by one external beat
    localparam int LOAD_ADDR_W       = 7;   // luma buffer row address width

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_REQ  = 2'd1,
        FSM_LOAD = 2'd2,
        FSM_DONE = 2'd3
    } load_state_t;

    // Counter width that stays legal for a count of one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fetch_luma_row_pack.sv
// Packs BEATS_PER_ROW external beats into one row, beat 0 in the MSBs.
// Latency: row strobe and data appear one cycle after the last beat of a row.
// Backpressure: none; beats are taken whenever beat_vld_i is high, gaps hold partial state.
module fetch_luma_row_pack
    import fetch_luma_load_ctrl_pkg::*;
#(
    parameter int PIXEL_WIDTH   = PIXEL_WIDTH_DEF,
    parameter int BEATS_PER_ROW = BEATS_PER_ROW_DEF
) (
    input  logic                                               clk,
    input  logic                                               rstn,
    input  logic                                               clr_i,
    input  logic                                               beat_vld_i,
    input  logic [BEAT_PIXELS*PIXEL_WIDTH-1:0]                 beat_dat_i,
    output logic                                               row_vld_o,
    output logic [BEATS_PER_ROW*BEAT_PIXELS*PIXEL_WIDTH-1:0]   row_dat_o
);

    localparam int BEAT_W = BEAT_PIXELS * PIXEL_WIDTH;
    localparam int ROW_W  = BEATS_PER_ROW * BEAT_W;
    localparam int BCW    = cnt_width(BEATS_PER_ROW);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS_PER_ROW - 1);

    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [ROW_W-1:0] row_q,      row_d;
    logic             row_vld_q,  row_vld_d;
    logic [ROW_W-1:0] row_dat_q,  row_dat_d;

    // Drop each beat into its slot; on the last beat hand the whole row to a separate
    // output register so the next row's beat 0 cannot disturb data being strobed.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        row_d      = row_q;
        row_vld_d  = 1'b0;
        row_dat_d  = row_dat_q;
        if (clr_i) begin
            beat_cnt_d = '0;
            row_d      = '0;
        end else if (beat_vld_i) begin
            for (int k = 0; k < BEATS_PER_ROW; k++) begin
                if (beat_cnt_q == BCW'(k)) begin
                    row_d[(BEATS_PER_ROW - k) * BEAT_W - 1 -: BEAT_W] = beat_dat_i;
                end
            end
            if (beat_cnt_q == LAST_BEAT) begin
                beat_cnt_d = '0;
                row_vld_d  = 1'b1;
                row_dat_d  = row_d;
            end else begin
                beat_cnt_d = beat_cnt_q + BCW'(1);
            end
        end
    end

    // Register beat counter, partial row and the outgoing row/strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt_q <= '0;
            row_q      <= '0;
            row_vld_q  <= 1'b0;
            row_dat_q  <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            row_q      <= row_d;
            row_vld_q  <= row_vld_d;
            row_dat_q  <= row_dat_d;
        end
    end

    assign row_vld_o = row_vld_q;
    assign row_dat_o = row_dat_q;

endmodule

// File: rtl/fetch_luma_load_ctrl.sv
// Fetches one luma reference window per LCU start and writes it row by row into the luma buffer.
// Latency: request one cycle after start; each row strobed one cycle after its last beat; done one cycle after the last row.
// Backpressure: request held until ext_ack_i; beats accepted only in LOAD, gaps tolerated; starts while busy are dropped.
module fetch_luma_load_ctrl
    import fetch_luma_load_ctrl_pkg::*;
#(
    parameter int PIXEL_WIDTH   = PIXEL_WIDTH_DEF,
    parameter int LOAD_ROWS     = LOAD_ROWS_DEF,
    parameter int BEATS_PER_ROW = BEATS_PER_ROW_DEF
) (
    input  logic                                               clk,
    input  logic                                               rstn,
    input  logic                                               sysif_start_i,
    input  logic [PIC_X_WIDTH-1:0]                             sysif_total_x_i,
    input  logic [PIC_Y_WIDTH-1:0]                             sysif_total_y_i,
    output logic                                               ext_req_o,
    output logic [PIC_X_WIDTH-1:0]                             ext_req_x_o,
    output logic [PIC_Y_WIDTH-1:0]                             ext_req_y_o,
    input  logic                                               ext_ack_i,
    input  logic                                               ext_rdata_valid_i,
    input  logic [BEAT_PIXELS*PIXEL_WIDTH-1:0]                 ext_rdata_i,
    output logic                                               ext_load_valid_o,
    output logic [LOAD_ADDR_W-1:0]                             ext_load_addr_o,
    output logic [BEATS_PER_ROW*BEAT_PIXELS*PIXEL_WIDTH-1:0]   ext_load_data_o,
    output logic                                               ext_load_done_o,
    output logic                                               busy_o
);

    localparam logic [LOAD_ADDR_W-1:0] LAST_ROW = LOAD_ADDR_W'(LOAD_ROWS - 1);

    load_state_t               state_q,   state_d;
    logic [PIC_X_WIDTH-1:0]    pos_x_q,   pos_x_d;
    logic [PIC_Y_WIDTH-1:0]    pos_y_q,   pos_y_d;
    logic [PIC_X_WIDTH-1:0]    req_x_q,   req_x_d;
    logic [PIC_Y_WIDTH-1:0]    req_y_q,   req_y_d;
    logic [LOAD_ADDR_W-1:0]    row_cnt_q, row_cnt_d;
    logic                      req_q,     req_d;
    logic                      busy_q,    busy_d;
    logic                      done_q,    done_d;

    logic                      row_vld;
    logic                      beat_vld;
    logic                      pack_clr;

    // Beats count only while loading; once the final row is strobed any stray beat in
    // that same cycle must not start a phantom row.
    assign beat_vld = ext_rdata_valid_i && (state_q == FSM_LOAD)
                      && !(row_vld && (row_cnt_q == LAST_ROW));
    assign pack_clr = (state_q == FSM_DONE);

    fetch_luma_row_pack #(
        .PIXEL_WIDTH   (PIXEL_WIDTH),
        .BEATS_PER_ROW (BEATS_PER_ROW)
    ) u_row_pack (
        .clk        (clk),
        .rstn       (rstn),
        .clr_i      (pack_clr),
        .beat_vld_i (beat_vld),
        .beat_dat_i (ext_rdata_i),
        .row_vld_o  (row_vld),
        .row_dat_o  (ext_load_data_o)
    );

    // Next-state, LCU position walk and row counting; outputs derive from the next state
    // so they are registered alongside it.
    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        req_x_d   = req_x_q;
        req_y_d   = req_y_q;
        row_cnt_d = row_cnt_q;
        case (state_q)
            FSM_IDLE: begin
                if (sysif_start_i) begin
                    state_d = FSM_REQ;
                    req_x_d = pos_x_q;
                    req_y_d = pos_y_q;
                    if (pos_x_q == sysif_total_x_i) begin
                        pos_x_d = '0;
                        if (pos_y_q == sysif_total_y_i) begin
                            pos_y_d = '0;
                        end else begin
                            pos_y_d = pos_y_q + PIC_Y_WIDTH'(1);
                        end
                    end else begin
                        pos_x_d = pos_x_q + PIC_X_WIDTH'(1);
                    end
                end
            end
            FSM_REQ: begin
                if (ext_ack_i) begin
                    state_d = FSM_LOAD;
                end
            end
            FSM_LOAD: begin
                if (row_vld) begin
                    row_cnt_d = row_cnt_q + LOAD_ADDR_W'(1);
                    if (row_cnt_q == LAST_ROW) begin
                        state_d = FSM_DONE;
                    end
                end
            end
            FSM_DONE: begin
                state_d   = FSM_IDLE;
                row_cnt_d = '0;
            end
            default: begin
                state_d = FSM_IDLE;
            end
        endcase
        req_d  = (state_d == FSM_REQ);
        busy_d = (state_d != FSM_IDLE);
        done_d = (state_d == FSM_DONE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= FSM_IDLE;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            req_x_q   <= '0;
            req_y_q   <= '0;
            row_cnt_q <= '0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            req_x_q   <= req_x_d;
            req_y_q   <= req_y_d;
            row_cnt_q <= row_cnt_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ext_req_o        = req_q;
    assign ext_req_x_o      = req_x_q;
    assign ext_req_y_o      = req_y_q;
    assign ext_load_valid_o = row_vld;
    assign ext_load_addr_o  = row_cnt_q;
    assign ext_load_done_o  = done_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_fetch_luma_load_ctrl.sv
// Directed bench for the luma window loader with a queue-based row model and per-cycle compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_luma_load_ctrl;
    import fetch_luma_load_ctrl_pkg::*;

    localparam int BW   = 256;
    localparam int RW   = 768;
    localparam int ROWS = 80;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [7:0]    total_x, total_y;
    logic          req;
    logic [7:0]    req_x, req_y;
    logic          ack;
    logic          rvld;
    logic [BW-1:0] rdat;
    logic          lvld;
    logic [6:0]    laddr;
    logic [RW-1:0] ldat;
    logic          ldone;
    logic          busy;

    always #5 clk = ~clk;

    fetch_luma_load_ctrl dut (
        .clk               (clk),
        .rstn              (rstn),
        .sysif_start_i     (start),
        .sysif_total_x_i   (total_x),
        .sysif_total_y_i   (total_y),
        .ext_req_o         (req),
        .ext_req_x_o       (req_x),
        .ext_req_y_o       (req_y),
        .ext_ack_i         (ack),
        .ext_rdata_valid_i (rvld),
        .ext_rdata_i       (rdat),
        .ext_load_valid_o  (lvld),
        .ext_load_addr_o   (laddr),
        .ext_load_data_o   (ldat),
        .ext_load_done_o   (ldone),
        .busy_o            (busy)
    );

    typedef struct packed {
        logic [6:0]    addr;
        logic [RW-1:0] dat;
    } row_t;

    row_t          exp_q[$];
    int            checks = 0;
    int            failures = 0;
    int            strobe_cnt = 0;
    bit            prev79 = 1'b0;
    bit            grab_first = 1'b0;
    logic [RW-1:0] first_row = '0;
    int            pos_idx = 0;
    int            last_rx = -1;
    int            last_ry = -1;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Beat payload: pixel 0 carries the beat number (1,2,3), the rest vary by load/row/beat.
    function automatic logic [BW-1:0] beat_val(input int load, input int row, input int beat);
        logic [BW-1:0] v;
        v = '0;
        for (int p = 0; p < 32; p++) begin
            v[BW-1-8*p -: 8] = (p == 0) ? 8'(beat + 1) : 8'(row * 7 + beat * 29 + p * 3 + load * 11);
        end
        return v;
    endfunction

    // Per-cycle compare: every strobe must match the next modelled row, and done must
    // appear exactly one cycle after the strobe of the last row.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            check("done_timing", RW'(ldone), RW'(prev79));
            prev79 = 1'b0;
            if (lvld) begin
                strobe_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual_addr=%0d required=no strobe", laddr);
                end else begin
                    row_t e;
                    e = exp_q.pop_front();
                    check("row_addr", RW'(laddr), RW'(e.addr));
                    check("row_data", ldat, e.dat);
                end
                if (grab_first && laddr == 7'd0) begin
                    first_row  = ldat;
                    grab_first = 1'b0;
                end
                prev79 = (laddr == 7'(ROWS - 1));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   RW'(req),   '0);
        check({tag, "_lvld"},  RW'(lvld),  '0);
        check({tag, "_done"},  RW'(ldone), '0);
        check({tag, "_busy"},  RW'(busy),  '0);
        check({tag, "_laddr"}, RW'(laddr), '0);
        check({tag, "_ldat"},  ldat,       '0);
    endtask

    // One window: start, request/ack handshake, 80 rows of beats, done.
    // start_row pulses a start mid-load; rst_row pulls reset instead of that row;
    // start_in_done pulses start during the DONE cycle.
    task automatic run_load(input int load_id, input int gap_max, input int start_row,
                            input int rst_row, input bit start_in_done);
        int  ex, ey, n, gap;
        bit  seen;
        ex = pos_idx % (int'(total_x) + 1);
        ey = (pos_idx / (int'(total_x) + 1)) % (int'(total_y) + 1);
        strobe_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (req) seen = 1'b1;
            n++;
        end
        check("req_seen", RW'(seen), RW'(1));
        if (!seen) return;
        check("req_x", RW'(req_x), RW'(ex));
        check("req_y", RW'(req_y), RW'(ey));
        last_rx = int'(req_x);
        last_ry = int'(req_y);
        pos_idx++;
        // Junk beats while waiting for ack must be discarded.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            rvld = 1'b1;
            rdat = {8{$urandom}};
            @(negedge clk);
            check("req_held", RW'(req), RW'(1));
            check("req_x_stable", RW'(req_x), RW'(ex));
        end
        @(posedge clk); #1;
        ack  = 1'b1;
        rvld = 1'b1;
        @(posedge clk); #1;
        ack  = 1'b0;
        rvld = 1'b0;
        @(negedge clk);
        check("req_drop", RW'(req), RW'(0));
        for (int r = 0; r < ROWS; r++) begin
            for (int b = 0; b < 3; b++) begin
                if (r == rst_row && b == 0) begin
                    rvld = 1'b0;
                    @(negedge clk); #1;
                    rstn = 1'b0;
                    #1;
                    check_all_zero("midrst");
                    check("midrst_rows", RW'(strobe_cnt), RW'(rst_row));
                    exp_q.delete();
                    prev79 = 1'b0;
                    repeat (2) @(posedge clk);
                    #1;
                    rstn = 1'b1;
                    pos_idx = 0;
                    return;
                end
                gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
                repeat (gap) begin
                    rvld = 1'b0;
                    rdat = {8{$urandom}};
                    @(posedge clk); #1;
                end
                rvld = 1'b1;
                rdat = beat_val(load_id, r, b);
                if (r == start_row && b == 0) start = 1'b1;
                if (b == 2) begin
                    exp_q.push_back({7'(r), beat_val(load_id, r, 0),
                                     beat_val(load_id, r, 1), beat_val(load_id, r, 2)});
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        rvld = 1'b0;
        if (start_in_done) begin
            seen = 1'b0;
            n = 0;
            while (!seen && n < 20) begin
                @(negedge clk);
                if (lvld && laddr == 7'(ROWS - 1)) seen = 1'b1;
                n++;
            end
            check("last_row_seen", RW'(seen), RW'(1));
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (5) @(negedge clk);
            check("done_start_ignored_req", RW'(req), RW'(0));
            check("done_start_ignored_busy", RW'(busy), RW'(0));
        end else begin
            seen = 1'b0;
            n = 0;
            while (!seen && n < 20) begin
                @(negedge clk);
                if (ldone) seen = 1'b1;
                n++;
            end
            check("done_seen", RW'(seen), RW'(1));
            @(negedge clk);
            check("idle_after_done", RW'(busy), RW'(0));
        end
        check("strobe_count", RW'(strobe_cnt), RW'(ROWS));
        check("queue_drained", RW'(exp_q.size()), RW'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // Request positions for the walk over a 3x2 LCU picture, in start order.
    int exp_x[11] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 0};
    int exp_y[11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0};

    initial begin
        rstn    = 1'b0;
        start   = 1'b0;
        ack     = 1'b0;
        rvld    = 1'b0;
        rdat    = '0;
        total_x = 8'd2;
        total_y = 8'd1;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        // Beats in IDLE must produce nothing (the compare process flags any strobe).
        rvld = 1'b1;
        rdat = {8{$urandom}};
        repeat (3) @(posedge clk);
        #1;
        rvld = 1'b0;

        // Back-to-back first window, then the rest of the position walk.
        grab_first = 1'b1;
        run_load(0, 0, -1, -1, 1'b0);
        check("lit_row0_beat0_msb", RW'(first_row[767:760]), RW'(8'h01));
        check("lit_row0_beat1_msb", RW'(first_row[511:504]), RW'(8'h02));
        check("lit_row0_beat2_msb", RW'(first_row[255:248]), RW'(8'h03));
        check("lit_pos_x_0", RW'(last_rx), RW'(exp_x[0]));
        check("lit_pos_y_0", RW'(last_ry), RW'(exp_y[0]));
        for (int i = 1; i < 7; i++) begin
            run_load(i, 0, -1, -1, 1'b0);
            check($sformatf("lit_pos_x_%0d", i), RW'(last_rx), RW'(exp_x[i]));
            check($sformatf("lit_pos_y_%0d", i), RW'(last_ry), RW'(exp_y[i]));
        end

        // Start at row 40 and in the DONE cycle: both ignored.
        run_load(7, 0, 40, -1, 1'b1);
        check("lit_pos_x_7", RW'(last_rx), RW'(exp_x[7]));
        check("lit_pos_y_7", RW'(last_ry), RW'(exp_y[7]));

        // Random 0..5 cycle gaps between beats.
        run_load(8, 5, -1, -1, 1'b0);
        check("lit_pos_x_8", RW'(last_rx), RW'(exp_x[8]));
        check("lit_pos_y_8", RW'(last_ry), RW'(exp_y[8]));

        // Reset at row 50, then the next start must request (0,0).
        run_load(9, 0, -1, 50, 1'b0);
        check("lit_pos_x_9", RW'(last_rx), RW'(exp_x[9]));
        check("lit_pos_y_9", RW'(last_ry), RW'(exp_y[9]));
        repeat (3) @(negedge clk);
        check("post_rst_done", RW'(ldone), RW'(0));
        check("post_rst_busy", RW'(busy), RW'(0));
        run_load(10, 0, -1, -1, 1'b0);
        check("lit_pos_x_10", RW'(last_rx), RW'(exp_x[10]));
        check("lit_pos_y_10", RW'(last_ry), RW'(exp_y[10]));

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
